instr_fetch: RTL and testbench

Instruction fetch stage sitting directly downstream of the PC register. It takes the current 10-bit PC and runs a req/ack read transaction on the instruction memory port. It holds the returned 16-bit instruction, tagged with its PC, until decode/control accepts it. It also handles flush on redirect (branch/jump/reset-vector) and a memory watchdog.

---
 rtl/instr_fetch.sv | 164 ++++++++++++++++
 tb/tb_instr_fetch.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : Instruction fetch stage. Issues a req/ack read on the
//            instruction memory for the current PC. Holds the returned
//            instruction, tagged with its PC, until decode takes it. Handles
//            flush/redirect and aborts a stalled memory access with a
//            watchdog.
// Ports    : clk, reset        - clock (rising edge), async active-high reset
//            fetch_en, pc      - fetch permission and address from PC block
//            flush             - redirect, discard held/in-flight instruction
//            imem_*            - registered req/addr out, ack/rdata in
//            instr, instr_pc,
//            instr_valid       - held instruction toward decode
//            instr_take        - decode consumes the held instruction
//            fetch_busy        - memory access outstanding (WAIT or DROP)
//            err_misalign      - 1-cycle pulse, odd fetch address
//            err_timeout       - 1-cycle pulse, watchdog abort
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 16,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_en,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               flush,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_take,
  output logic               fetch_busy,
  output logic               err_misalign,
  output logic               err_timeout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  // The abort fires on the cycle the counter would reach TIMEOUT, so the
  // request is held for exactly TIMEOUT cycles without an ack.
  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT - 1);

  state_t               state, state_nxt;
  logic [7:0]           wdog, wdog_nxt;
  logic [ADDR_W-1:0]    addr_nxt;
  logic                 req_nxt;
  logic [INSTR_W-1:0]   instr_nxt;
  logic [ADDR_W-1:0]    ipc_nxt;
  logic                 mis_nxt;
  logic                 to_nxt;

  assign instr_valid = (state == S_HOLD);
  assign fetch_busy  = (state == S_WAIT) || (state == S_DROP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      wdog         <= '0;
      imem_addr    <= '0;
      imem_req     <= 1'b0;
      instr        <= '0;
      instr_pc     <= '0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state        <= state_nxt;
      wdog         <= wdog_nxt;
      imem_addr    <= addr_nxt;
      imem_req     <= req_nxt;
      instr        <= instr_nxt;
      instr_pc     <= ipc_nxt;
      err_misalign <= mis_nxt;
      err_timeout  <= to_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wdog_nxt  = wdog;
    addr_nxt  = imem_addr;
    req_nxt   = imem_req;
    instr_nxt = instr;
    ipc_nxt   = instr_pc;
    mis_nxt   = 1'b0;
    to_nxt    = 1'b0;

    case (state)
      S_IDLE: begin
        // flush overrides fetch_en
        if (!flush && fetch_en) begin
          if (pc[0]) begin
            mis_nxt = 1'b1;
          end else begin
            addr_nxt  = pc;
            req_nxt   = 1'b1;
            wdog_nxt  = '0;
            state_nxt = S_WAIT;
          end
        end
      end

      S_WAIT, S_DROP: begin
        if (imem_ack) begin
          req_nxt   = 1'b0;
          state_nxt = S_IDLE;
          // Only a live (not flushed) access delivers its data.
          if (state == S_WAIT && !flush) begin
            instr_nxt = imem_rdata;
            ipc_nxt   = imem_addr;
            state_nxt = S_HOLD;
          end
        end else if (wdog >= WD_LIMIT) begin
          req_nxt   = 1'b0;
          to_nxt    = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          if (wdog != 8'hFF) begin
            wdog_nxt = wdog + 8'd1;
          end
          // The request stays up; the data is marked for discard instead.
          if (state == S_WAIT && flush) begin
            state_nxt = S_DROP;
          end
        end
      end

      S_HOLD: begin
        if (flush) begin
          state_nxt = S_IDLE;
        end else if (instr_take) begin
          state_nxt = S_IDLE;
          if (fetch_en) begin
            if (pc[0]) begin
              mis_nxt = 1'b1;
            end else begin
              addr_nxt  = pc;
              req_nxt   = 1'b1;
              wdog_nxt  = '0;
              state_nxt = S_WAIT;
            end
          end
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Self-checking bench for instr_fetch. Directed scenarios followed
//            by randomized traffic, compared every cycle against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  localparam int ADDR_W  = 10;
  localparam int INSTR_W = 16;
  localparam int TIMEOUT = 15;

  logic               clk = 1'b0;
  logic               reset;
  logic               fetch_en;
  logic [ADDR_W-1:0]  pc;
  logic               flush;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_req;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               instr_take;
  logic               fetch_busy;
  logic               err_misalign;
  logic               err_timeout;

  always #5 clk = ~clk;

  instr_fetch #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_en    (fetch_en),
    .pc          (pc),
    .flush       (flush),
    .imem_addr   (imem_addr),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_take  (instr_take),
    .fetch_busy  (fetch_busy),
    .err_misalign(err_misalign),
    .err_timeout (err_timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one outstanding memory access at most, a flag saying
  // whether its data is still wanted, and one held instruction slot.
  bit                 m_pending;
  bit                 m_discard;
  bit                 m_have;
  int                 m_tries;
  logic [ADDR_W-1:0]  m_addr;
  logic [INSTR_W-1:0] m_instr;
  logic [ADDR_W-1:0]  m_ipc;
  bit                 m_mis;
  bit                 m_to;

  task automatic m_reset();
    m_pending = 0; m_discard = 0; m_have = 0; m_tries = 0;
    m_addr = '0; m_instr = '0; m_ipc = '0; m_mis = 0; m_to = 0;
  endtask

  task automatic m_start(input logic [ADDR_W-1:0] a);
    if (a[0]) begin
      m_mis = 1;
    end else begin
      m_pending = 1; m_discard = 0; m_tries = 0; m_addr = a;
    end
  endtask

  task automatic m_step(input bit fe, input logic [ADDR_W-1:0] p, input bit fl,
                        input bit ack, input logic [INSTR_W-1:0] rd, input bit tk);
    m_mis = 0;
    m_to  = 0;
    if (m_pending) begin
      if (ack) begin
        m_pending = 0;
        if (!m_discard && !fl) begin
          m_have = 1; m_instr = rd; m_ipc = m_addr;
        end
        m_discard = 0;
      end else if (m_tries + 1 >= TIMEOUT) begin
        m_pending = 0; m_discard = 0; m_to = 1;
      end else begin
        m_tries++;
        if (fl) m_discard = 1;
      end
    end else if (m_have) begin
      if (fl) begin
        m_have = 0;
      end else if (tk) begin
        m_have = 0;
        if (fe) m_start(p);
      end
    end else if (!fl && fe) begin
      m_start(p);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("imem_req",     32'(imem_req),     32'(m_pending));
    chk("imem_addr",    32'(imem_addr),    32'(m_addr));
    chk("instr_valid",  32'(instr_valid),  32'(m_have));
    chk("fetch_busy",   32'(fetch_busy),   32'(m_pending));
    chk("instr",        32'(instr),        32'(m_instr));
    chk("instr_pc",     32'(instr_pc),     32'(m_ipc));
    chk("err_misalign", 32'(err_misalign), 32'(m_mis));
    chk("err_timeout",  32'(err_timeout),  32'(m_to));
  endtask

  // Called at a falling edge: drive inputs, advance model, then compare at
  // the next falling edge.
  task automatic cyc(input bit fe, input logic [ADDR_W-1:0] p, input bit fl,
                     input bit ack, input logic [INSTR_W-1:0] rd, input bit tk);
    fetch_en = fe; pc = p; flush = fl; imem_ack = ack; imem_rdata = rd; instr_take = tk;
    m_step(fe, p, fl, ack, rd, tk);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [ADDR_W-1:0]  rp;
    logic [INSTR_W-1:0] rd;
    bit                 ra;

    reset = 1'b1; fetch_en = 0; pc = '0; flush = 0;
    imem_ack = 0; imem_rdata = '0; instr_take = 0;
    m_reset();
    repeat (2) @(negedge clk);
    check_all();
    reset = 1'b0;

    // Zero-wait fetch at 0x004
    cyc(1, 10'h004, 0, 0, 16'h0, 0);
    chk("req_latency", 32'(imem_req), 32'd1);
    cyc(0, 10'h000, 0, 1, 16'hA5C3, 0);
    chk("instr_a5c3", 32'(instr), 32'hA5C3);
    chk("instr_pc_004", 32'(instr_pc), 32'h004);
    cyc(0, 10'h000, 0, 0, 16'h0, 0);
    cyc(1, 10'h008, 0, 0, 16'h0, 0);
    chk("hold_until_take", 32'(instr_valid), 32'd1);
    cyc(0, 10'h000, 0, 0, 16'h0, 1);

    // Ack delayed by three cycles
    cyc(1, 10'h020, 0, 0, 16'h0, 0);
    repeat (3) cyc(0, 10'h3FE, 0, 0, 16'hFFFF, 0);
    chk("delay_addr_stable", 32'(imem_addr), 32'h020);
    cyc(0, 10'h000, 0, 1, 16'h5A5A, 0);
    chk("delay_valid", 32'(instr_valid), 32'd1);
    cyc(0, 10'h000, 0, 0, 16'h0, 1);

    // Flush in WAIT, ack two cycles later
    cyc(1, 10'h024, 0, 0, 16'h0, 0);
    cyc(0, 10'h000, 1, 0, 16'h0, 0);
    cyc(0, 10'h000, 1, 0, 16'h0, 0);
    chk("drop_req_held", 32'(imem_req), 32'd1);
    cyc(0, 10'h000, 0, 1, 16'h1234, 0);
    chk("drop_no_valid", 32'(instr_valid), 32'd0);

    // HOLD with flush + take + fetch_en together, then fetch 0x010
    cyc(1, 10'h028, 0, 0, 16'h0, 0);
    cyc(0, 10'h000, 0, 1, 16'hBEEF, 0);
    cyc(1, 10'h030, 1, 0, 16'h0, 1);
    chk("flush_prio_req", 32'(imem_req), 32'd0);
    cyc(1, 10'h010, 0, 0, 16'h0, 0);
    cyc(0, 10'h000, 0, 1, 16'hC0DE, 0);
    chk("refetch_pc", 32'(instr_pc), 32'h010);
    cyc(0, 10'h000, 0, 0, 16'h0, 1);

    // Misaligned fetch
    cyc(1, 10'h005, 0, 0, 16'h0, 0);
    chk("misalign_pulse", 32'(err_misalign), 32'd1);
    cyc(0, 10'h000, 0, 0, 16'h0, 0);

    // Watchdog
    cyc(1, 10'h040, 0, 0, 16'h0, 0);
    repeat (TIMEOUT) cyc(0, 10'h000, 0, 0, 16'h0, 0);
    chk("timeout_pulse", 32'(err_timeout), 32'd1);
    cyc(1, 10'h044, 0, 0, 16'h0, 0);
    cyc(0, 10'h000, 0, 1, 16'h7777, 0);
    cyc(0, 10'h000, 0, 0, 16'h0, 1);

    // Reset in the middle of WAIT
    cyc(1, 10'h050, 0, 0, 16'h0, 0);
    reset = 1'b1;
    #1;
    m_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rp = ADDR_W'($urandom);
      if ($urandom_range(0, 7) != 0) rp[0] = 1'b0;
      rd = INSTR_W'($urandom);
      ra = m_pending && ($urandom_range(0, 3) == 0);
      cyc(bit'($urandom_range(0, 1)), rp, ($urandom_range(0, 7) == 0), ra, rd,
          bit'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
